// File: rtl/cnt_pkg.sv
// Shared encodings for the counter family: count mode and direction selects.
package cnt_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/cnt_ctrl_if.sv
// Control/status bundle for cnt_ctrl: the master drives controls, the slave returns count and flags.
interface cnt_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PRE_W = 4
);

  logic             en;
  logic             up_dn;
  logic             mode;
  logic [WIDTH-1:0] max_val;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [PRE_W-1:0] pre_div;
  logic             ovf_clr;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_dn, mode, max_val, load, load_val, pre_div, ovf_clr,
    input  cnt, tc, ovf
  );

  modport slave (
    input  en, up_dn, mode, max_val, load, load_val, pre_div, ovf_clr,
    output cnt, tc, ovf
  );

endinterface

// File: rtl/cnt_prescaler.sv
// Enable prescaler: tick is high in every (pre_div+1)-th enabled cycle; clr restarts the phase.
module cnt_prescaler #(
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] pre_div,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = (pre_cnt_q == pre_div);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// General-purpose up/down counter with modulo, wrap/saturate, load, prescaler and tc/ovf flags.
module cnt_ctrl
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PRE_W = 4
) (
  input logic       clk,
  input logic       rst,
  cnt_ctrl_if.slave bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             step;
  logic             at_bound;

  cnt_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .clr     (bus.load),
    .pre_div (bus.pre_div),
    .tick    (tick)
  );

  always_comb begin
    step     = bus.en & tick & ~bus.load;
    // Counting up from above max_val is treated as already at the boundary.
    at_bound = (bus.up_dn == DIR_UP) ? (cnt_q >= bus.max_val) : (cnt_q == '0);
    cnt_d    = cnt_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q & ~bus.ovf_clr;
    if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (step) begin
      if (at_bound) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (bus.up_dn == DIR_UP) begin
          cnt_d = (bus.mode == MODE_SAT) ? bus.max_val : '0;
        end else begin
          cnt_d = (bus.mode == MODE_SAT) ? '0 : bus.max_val;
        end
      end else begin
        cnt_d = (bus.up_dn == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Scoreboard bench for cnt_ctrl: the driver queues the expected post-edge state, a monitor checks it.
module tb_cnt_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cnt_ctrl_if #(.WIDTH(4), .PRE_W(4)) bus ();

  cnt_ctrl #(
    .WIDTH (4),
    .PRE_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [5:0] exp_q[$];
  string      nm_q[$];
  int         total = 0;
  int         bad   = 0;

  // Expected {cnt, tc, ovf} is queued before the edge and checked just after it.
  task automatic expect_cyc(input logic [3:0] c, input logic t, input logic o, input string nm);
    exp_q.push_back({c, t, o});
    nm_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [5:0] e;
    logic [5:0] got;
    string      n;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = nm_q.pop_front();
      got = {bus.cnt, bus.tc, bus.ovf};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got cnt=%0d tc=%b ovf=%b, want cnt=%0d tc=%b ovf=%b",
                 n, got[5:2], got[1], got[0], e[5:2], e[1], e[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.up_dn = 1'b1; bus.mode = 1'b0; bus.max_val = 4'd15;
    bus.load = 1'b0; bus.load_val = 4'd0; bus.pre_div = 4'd0; bus.ovf_clr = 1'b0;

    // Reset state
    expect_cyc(4'd0, 1'b0, 1'b0, "reset0");
    expect_cyc(4'd0, 1'b0, 1'b0, "reset1");

    // Legacy free-run 0..15,0,1,2
    rst = 1'b0; bus.en = 1'b1;
    for (int i = 1; i <= 18; i++)
      expect_cyc(4'(i % 16), (i == 16), (i >= 16), "freerun");

    // Modulo-10 up count
    bus.load = 1'b1; bus.load_val = 4'd0; bus.max_val = 4'd9;
    expect_cyc(4'd0, 1'b0, 1'b1, "mod_load");
    bus.load = 1'b0;
    for (int i = 1; i <= 20; i++)
      expect_cyc(4'(i % 10), (i % 10 == 0), 1'b1, "mod10");

    bus.en = 1'b0; bus.ovf_clr = 1'b1;
    expect_cyc(4'd0, 1'b0, 1'b0, "ovf_clr0");
    bus.ovf_clr = 1'b0;

    // Saturating down count from 3
    bus.load = 1'b1; bus.load_val = 4'd3;
    expect_cyc(4'd3, 1'b0, 1'b0, "sat_load");
    bus.load = 1'b0; bus.en = 1'b1; bus.up_dn = 1'b0; bus.mode = 1'b1;
    expect_cyc(4'd2, 1'b0, 1'b0, "satdn2");
    expect_cyc(4'd1, 1'b0, 1'b0, "satdn1");
    expect_cyc(4'd0, 1'b0, 1'b0, "satdn0");
    expect_cyc(4'd0, 1'b1, 1'b1, "satdn_hold0");
    expect_cyc(4'd0, 1'b1, 1'b1, "satdn_hold1");
    bus.en = 1'b0;
    expect_cyc(4'd0, 1'b0, 1'b1, "satdn_idle");

    // Wrap down from 0 goes to max_val
    bus.en = 1'b1; bus.mode = 1'b0;
    expect_cyc(4'd9, 1'b1, 1'b1, "wrapdn_max");
    expect_cyc(4'd8, 1'b0, 1'b1, "wrapdn_8");

    // Count above max_val: up saturates to max_val, down just decrements
    bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd12;
    expect_cyc(4'd12, 1'b0, 1'b1, "over_load");
    bus.load = 1'b0; bus.en = 1'b1; bus.up_dn = 1'b1; bus.mode = 1'b1;
    expect_cyc(4'd9, 1'b1, 1'b1, "over_upsat");
    expect_cyc(4'd9, 1'b1, 1'b1, "over_upsat2");
    bus.en = 1'b0; bus.load = 1'b1;
    expect_cyc(4'd12, 1'b0, 1'b1, "over_load2");
    bus.load = 1'b0; bus.en = 1'b1; bus.up_dn = 1'b0; bus.mode = 1'b0;
    expect_cyc(4'd11, 1'b0, 1'b1, "over_dn");

    // Prescaler divide-by-3 with a pause that must keep the phase
    bus.en = 1'b0; bus.up_dn = 1'b1; bus.max_val = 4'd15; bus.pre_div = 4'd2;
    bus.load = 1'b1; bus.load_val = 4'd0;
    expect_cyc(4'd0, 1'b0, 1'b1, "pre_load");
    bus.load = 1'b0; bus.en = 1'b1;
    expect_cyc(4'd0, 1'b0, 1'b1, "pre_a");
    expect_cyc(4'd0, 1'b0, 1'b1, "pre_b");
    expect_cyc(4'd1, 1'b0, 1'b1, "pre_c");
    expect_cyc(4'd1, 1'b0, 1'b1, "pre_d");
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++)
      expect_cyc(4'd1, 1'b0, 1'b1, "pre_pause");
    bus.en = 1'b1;
    expect_cyc(4'd1, 1'b0, 1'b1, "pre_e");
    expect_cyc(4'd2, 1'b0, 1'b1, "pre_f");
    expect_cyc(4'd2, 1'b0, 1'b1, "pre_g");
    expect_cyc(4'd2, 1'b0, 1'b1, "pre_h");
    expect_cyc(4'd3, 1'b0, 1'b1, "pre_i");

    // Load beats a due step; reset beats load
    bus.pre_div = 4'd0; bus.load = 1'b1; bus.load_val = 4'd7;
    expect_cyc(4'd7, 1'b0, 1'b1, "prio_load");
    bus.load = 1'b0;
    expect_cyc(4'd8, 1'b0, 1'b1, "prio_step");
    rst = 1'b1; bus.load = 1'b1;
    expect_cyc(4'd0, 1'b0, 1'b0, "prio_rst");
    rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
    expect_cyc(4'd0, 1'b0, 1'b0, "prio_idle");

    // Sticky ovf: set beats clear, then clear alone
    bus.max_val = 4'd0; bus.mode = 1'b0; bus.en = 1'b1; bus.ovf_clr = 1'b1;
    expect_cyc(4'd0, 1'b1, 1'b1, "sticky_setwin");
    bus.en = 1'b0;
    expect_cyc(4'd0, 1'b0, 1'b0, "sticky_clr");
    bus.ovf_clr = 1'b0; bus.en = 1'b1;
    expect_cyc(4'd0, 1'b1, 1'b1, "max0_step0");
    expect_cyc(4'd0, 1'b1, 1'b1, "max0_step1");
    rst = 1'b1;
    expect_cyc(4'd0, 1'b0, 1'b0, "rst_kills_flags");
    rst = 1'b0; bus.en = 1'b0;

    // Full-range saturate at all-ones
    bus.max_val = 4'd15; bus.mode = 1'b1; bus.load = 1'b1; bus.load_val = 4'd15;
    expect_cyc(4'd15, 1'b0, 1'b0, "full_load");
    bus.load = 1'b0; bus.en = 1'b1;
    expect_cyc(4'd15, 1'b1, 1'b1, "full_sat");
    bus.en = 1'b0;
    expect_cyc(4'd15, 1'b0, 1'b1, "full_idle");

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
